// File: rtl/pattern_frame_ctrl_if.sv
// Host/detector handshake bundle for pattern_frame_ctrl.
interface pattern_frame_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             abort;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] hit_count;
  logic             det_clr;
  logic             det_en;
  logic             det_bit;
  logic             det_hit;

  modport master (
    output start, data_in, abort, det_hit,
    input  busy, done, hit_count, det_clr, det_en, det_bit
  );

  modport slave (
    input  start, data_in, abort, det_hit,
    output busy, done, hit_count, det_clr, det_en, det_bit
  );
endinterface

// File: rtl/pattern_frame_ctrl.sv
// Streams a WIDTH-bit frame MSB-first into a registered serial pattern
// detector, aligns its one-cycle-late hit output and reports the hit count.
module pattern_frame_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input logic               clk,
  input logic               rst_n,
  pattern_frame_ctrl_if.slave bus
);

  localparam int unsigned BCW = $clog2(WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;

  logic [WIDTH-1:0] r_shift;
  logic [BCW-1:0]   r_bit_cnt;
  logic [CNT_W-1:0] r_count;
  logic             r_en_d;

  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_hit_count;
  logic             r_det_clr;
  logic             r_det_en;
  logic             r_det_bit;

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next   = S_CLEAR;
          w_accept = 1'b1;
        end
      end
      S_CLEAR: w_next = bus.abort ? S_IDLE : S_SHIFT;
      S_SHIFT: begin
        if (bus.abort)                 w_next = S_IDLE;
        else if (r_bit_cnt == LAST_BIT) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = bus.abort ? S_IDLE : S_DONE;
      S_DONE: begin
        if (bus.start) begin
          w_next   = S_CLEAR;
          w_accept = 1'b1;
        end else begin
          w_next   = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Strobes are decoded from the next state so they line up with the state
  // they belong to; done/hit_count are taken from the DONE state itself,
  // which lands them one cycle after DONE once the DRAIN sample is counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_count     <= '0;
      r_en_d      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_hit_count <= '0;
      r_det_clr   <= 1'b0;
      r_det_en    <= 1'b0;
      r_det_bit   <= 1'b0;
    end else begin
      r_en_d    <= r_det_en;
      r_busy    <= (w_next == S_CLEAR) || (w_next == S_SHIFT) || (w_next == S_DRAIN);
      r_det_clr <= (w_next == S_CLEAR);
      r_det_en  <= (w_next == S_SHIFT);
      r_det_bit <= (w_next == S_SHIFT) ? r_shift[WIDTH-1] : 1'b0;
      r_done    <= (r_state == S_DONE);

      if (r_state == S_DONE) r_hit_count <= r_count;

      if (w_accept) begin
        r_shift   <= bus.data_in;
        r_bit_cnt <= '0;
        r_count   <= '0;
      end else begin
        if (w_next == S_SHIFT) r_shift <= r_shift << 1;
        if (r_state == S_SHIFT) r_bit_cnt <= r_bit_cnt + BCW'(1);
        if (r_en_d && bus.det_hit && (r_count != '1)) r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.hit_count = r_hit_count;
  assign bus.det_clr   = r_det_clr;
  assign bus.det_en    = r_det_en;
  assign bus.det_bit   = r_det_bit;

endmodule

// File: doc/pattern_frame_ctrl.md
Name: pattern_frame_ctrl

Overview:
- Sequencer for the registered-output serial pattern detector.
- Accepts a WIDTH-bit frame from the host and clears the detector state.
- Streams the frame into the detector MSB-first, one bit per cycle.
- Aligns the detector's one-cycle-late hit output and counts hits over the frame, then reports the count with a done pulse.

Parameters:
- WIDTH, 8, frame length in bits; must be >= 2.
- CNT_W, 4, hit counter width; must hold WIDTH, so 2**CNT_W-1 >= WIDTH.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  frame request; sampled in IDLE and DONE only.
- data_in  input  WIDTH  frame bits; captured on the cycle start is accepted.
- abort  input  1  cancels a frame in progress.
- busy  output  1  high in CLEAR, SHIFT and DRAIN.
- done  output  1  one-cycle pulse when a frame completes.
- hit_count  output  CNT_W  hits in the last completed frame.
- det_clr  output  1  detector state clear, one cycle.
- det_en  output  1  detector input-valid strobe.
- det_bit  output  1  serial bit into the detector.
- det_hit  input  1  detector output, registered by the detector.

Behaviour:
- Reset (rst_n=0, async) forces the following; resetting mid-frame discards the frame silently:
  - state=IDLE
  - busy=0, done=0, det_clr=0, det_en=0, det_bit=0
  - hit_count=0, internal shift register=0, bit counter=0, hit-align flag=0
- All outputs are registered.
- States: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- IDLE/DONE, start=1:
  - latch data_in into shift_reg, zero the running count, go to CLEAR.
  - start=0: hold; DONE falls to IDLE after one cycle.
- CLEAR (1 cycle): det_clr=1, det_en=0 -> SHIFT.
- SHIFT (exactly WIDTH cycles): det_en=1 and det_bit=shift_reg[WIDTH-1]; shift left by 1 each cycle; bit counter counts 0..WIDTH-1. After the last bit -> DRAIN.
- DRAIN (1 cycle): det_en=0, det_bit=0; collects the hit for the final bit -> DONE.
- DONE (1 cycle):
  - done=1, and hit_count is loaded with the running count on entry.
  - start=1 here is accepted (back-to-back frames) -> CLEAR.
- Hit alignment:
  - Flag en_d = det_en delayed one cycle.
  - Running count increments when en_d=1 and det_hit=1.
  - Exactly WIDTH samples are taken: the first in the second SHIFT cycle, the last in DRAIN.
  - det_hit while en_d=0 is ignored, including during CLEAR and IDLE.
- Count saturates at 2**CNT_W-1; it never wraps.
- hit_count holds its value until the next DONE; it is not cleared by start or abort.
- Latency: start accepted at cycle T -> det_clr at T+1 -> first det_en at T+2 -> done at T+WIDTH+4. Frame period is WIDTH+3 cycles when start is held.
- start in CLEAR, SHIFT or DRAIN is ignored; data_in is not re-captured.
- abort:
  - In CLEAR, SHIFT or DRAIN: next cycle state=IDLE, det_en=0, det_bit=0; no done pulse; hit_count unchanged.
  - abort wins over everything in those states.
  - abort is ignored in IDLE and DONE.
  - abort and start both high in DONE: start wins.
- det_clr and det_en are never high in the same cycle.

Test Plan:
- Bench detector model: det_hit <= det_en & det_bit, registered, cleared by det_clr.
- Reset mid-SHIFT (WIDTH=8, data 8'hFF, rst_n low on 3rd SHIFT cycle) -> all outputs 0 immediately (async), state IDLE, no done; after release, start with 8'h0F -> hit_count=4.
- Single frame data_in=8'hA5, start at T -> det_clr at T+1; det_bit sequence 1,0,1,0,0,1,0,1 on T+2..T+9; done=1 only at T+12; hit_count=4.
- Back-to-back: start held high, frames 8'hFF then 8'h00 -> done pulses 11 cycles apart; hit_count=8, then 0; det_en low for exactly 3 cycles between frames.
- Last-bit hit: data 8'h01 -> only hit sampled in DRAIN; hit_count=1 (verifies alignment; a design that drops the DRAIN sample gives 0).
- Abort: 8'hFF started after a completed frame with count 3, abort on 5th SHIFT cycle -> det_en=0 next cycle, no done, hit_count stays 3; start ignored while busy, as shown by a start pulse in SHIFT causing no restart.
- Saturation (WIDTH=8, CNT_W=2): data 8'hFF -> hit_count=3.
